// File: rtl/regfile_pkg.sv
// Shared widths and write-back request type for the register-file write path.
package regfile_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_slot.sv
// One-entry valid/ready holding register for a write-back source.
module regfile_wb_slot #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_payload,
  input  logic         i_drain,
  output logic         o_full,
  output logic         o_load,
  output logic [W-1:0] o_payload
);
  logic         r_full;
  logic [W-1:0] r_payload;

  // A granted slot can take a new entry on the same edge it drains.
  assign o_ready   = !r_full | i_drain;
  assign o_load    = i_valid & o_ready;
  assign o_full    = r_full;
  assign o_payload = r_payload;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
    end else if (o_load) begin
      r_full <= 1'b1;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (o_load) begin
      r_payload <= i_payload;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load/multi-cycle write-backs onto the single regfile write port,
// oldest-first, and exports a pending-write mask for decode hazard stalls.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_W    = regfile_pkg::ADDR_W,
  parameter int DATA_W    = regfile_pkg::DATA_W,
  parameter bit DROP_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_valid,
  output logic                 p0_ready,
  input  logic [ADDR_W-1:0]    p0_addr,
  input  logic [DATA_W-1:0]    p0_data,
  input  logic                 p1_valid,
  output logic                 p1_ready,
  input  logic [ADDR_W-1:0]    p1_addr,
  input  logic [DATA_W-1:0]    p1_data,
  output logic                 we_o,
  output logic [ADDR_W-1:0]    waddr_o,
  output logic [DATA_W-1:0]    wdata_o,
  output logic [2**ADDR_W-1:0] pending_o,
  output logic                 idle_o
);
  localparam int PL_W = ADDR_W + DATA_W;
  localparam int NREG = 2 ** ADDR_W;

  logic              w_full0, w_full1, w_load0, w_load1, w_g0, w_g1;
  logic              w_next0, w_next1, w_older_nxt;
  logic [PL_W-1:0]   w_s0, w_s1;
  logic [ADDR_W-1:0] w_a0, w_a1, w_gaddr;
  logic [DATA_W-1:0] w_gdata;
  logic [NREG-1:0]   w_pend;

  logic              r_older;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  regfile_wb_slot #(.W(PL_W)) u_slot0 (
    .clk(clk), .rst(rst), .i_valid(p0_valid), .o_ready(p0_ready),
    .i_payload({p0_addr, p0_data}), .i_drain(w_g0),
    .o_full(w_full0), .o_load(w_load0), .o_payload(w_s0)
  );

  regfile_wb_slot #(.W(PL_W)) u_slot1 (
    .clk(clk), .rst(rst), .i_valid(p1_valid), .o_ready(p1_ready),
    .i_payload({p1_addr, p1_data}), .i_drain(w_g1),
    .o_full(w_full1), .o_load(w_load1), .o_payload(w_s1)
  );

  assign w_a0 = w_s0[PL_W-1 -: ADDR_W];
  assign w_a1 = w_s1[PL_W-1 -: ADDR_W];

  // r_older: 0 = slot 0 holds the older entry, 1 = slot 1 does.
  assign w_g0    = w_full0 & (!w_full1 | !r_older);
  assign w_g1    = w_full1 & (!w_full0 |  r_older);
  assign w_gaddr = w_g1 ? w_a1 : w_a0;
  assign w_gdata = w_g1 ? w_s1[DATA_W-1:0] : w_s0[DATA_W-1:0];

  assign w_next0 = w_load0 | (w_full0 & !w_g0);
  assign w_next1 = w_load1 | (w_full1 & !w_g1);

  always_comb begin
    w_older_nxt = r_older;
    if (w_load0 && w_load1) begin
      w_older_nxt = 1'b1;
    end else if (w_load0) begin
      w_older_nxt = w_next1;
    end else if (w_load1) begin
      w_older_nxt = !w_next0;
    end else if (w_next0 && !w_next1) begin
      w_older_nxt = 1'b0;
    end else if (w_next1 && !w_next0) begin
      w_older_nxt = 1'b1;
    end
  end

  // Write stage register feeding the regfile port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_older <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_older <= w_older_nxt;
      if (w_g0 || w_g1) begin
        r_we    <= !(DROP_ZERO && (w_gaddr == ADDR_W'(ZERO_REG)));
        r_waddr <= w_gaddr;
        r_wdata <= w_gdata;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  always_comb begin
    w_pend = '0;
    if (w_full0) w_pend[w_a0] = 1'b1;
    if (w_full1) w_pend[w_a1] = 1'b1;
    if (r_we)    w_pend[r_waddr] = 1'b1;
    if (DROP_ZERO) w_pend[ZERO_REG] = 1'b0;
  end

  assign we_o      = r_we;
  assign waddr_o   = r_waddr;
  assign wdata_o   = r_wdata;
  assign pending_o = w_pend;
  assign idle_o    = !w_full0 & !w_full1 & !r_we;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter with a behavioural regfile on the write port.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic              clk, rst;
  logic              p0_valid, p0_ready, p1_valid, p1_ready;
  logic [ADDR_W-1:0] p0_addr, p1_addr, waddr_o;
  logic [DATA_W-1:0] p0_data, p1_data, wdata_o;
  logic              we_o, idle_o;
  logic [NUM_REGS-1:0] pending_o;
  logic [DATA_W-1:0] rf [NUM_REGS];

  int n_chk = 0;
  int n_fail = 0;

  regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DROP_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .pending_o(pending_o), .idle_o(idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (we_o) rf[waddr_o] <= wdata_o;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    p0_valid = 1'b0; p1_valid = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_data = '0; p1_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step(); step();
    n_chk++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%0b want=0", we_o); end
    n_chk++; if (pending_o !== '0) begin n_fail++; $display("FAIL reset_pending got=%h want=0", pending_o); end
    n_chk++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%0b want=1", idle_o); end
    rst = 1'b0;
    #1;
    n_chk++; if ({p0_ready, p1_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready got=%b want=11", {p0_ready, p1_ready}); end
    n_chk++; if (waddr_o !== '0 || wdata_o !== '0) begin n_fail++; $display("FAIL reset_wport got=%h/%h want=0/0", waddr_o, wdata_o); end
  endtask

  task automatic test_single();
    p0_valid = 1'b1; p0_addr = 5'd5; p0_data = 32'hDEADBEEF;
    #1;
    n_chk++; if (p0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%0b want=1", p0_ready); end
    step();
    idle_inputs();
    #1;
    n_chk++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL single_we_t got=%0b want=0", we_o); end
    n_chk++; if (pending_o !== 32'h0000_0020) begin n_fail++; $display("FAIL single_pend_t got=%h want=00000020", pending_o); end
    step();
    n_chk++; if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin n_fail++; $display("FAIL single_write got=%0b/%0d/%h want=1/5/deadbeef", we_o, waddr_o, wdata_o); end
    n_chk++; if (pending_o !== 32'h0000_0020) begin n_fail++; $display("FAIL single_pend_t1 got=%h want=00000020", pending_o); end
    step();
    n_chk++; if (we_o !== 1'b0 || pending_o !== '0) begin n_fail++; $display("FAIL single_done got=%0b/%h want=0/0", we_o, pending_o); end
    n_chk++; if (rf[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rf got=%h want=deadbeef", rf[5]); end
    n_chk++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL single_idle got=%0b want=1", idle_o); end
  endtask

  task automatic test_collision();
    p0_valid = 1'b1; p0_addr = 5'd7; p0_data = 32'd1;
    p1_valid = 1'b1; p1_addr = 5'd7; p1_data = 32'd2;
    #1;
    n_chk++; if ({p0_ready, p1_ready} !== 2'b11) begin n_fail++; $display("FAIL coll_ready got=%b want=11", {p0_ready, p1_ready}); end
    step();
    idle_inputs();
    #1;
    n_chk++; if (p1_ready !== 1'b1) begin n_fail++; $display("FAIL coll_p1_drain got=%0b want=1", p1_ready); end
    n_chk++; if (pending_o !== 32'h0000_0080) begin n_fail++; $display("FAIL coll_pend got=%h want=00000080", pending_o); end
    step();
    n_chk++; if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd7, 32'd2}) begin n_fail++; $display("FAIL coll_first got=%0b/%0d/%0d want=1/7/2", we_o, waddr_o, wdata_o); end
    n_chk++; if (p0_ready !== 1'b1) begin n_fail++; $display("FAIL coll_p0_ready got=%0b want=1", p0_ready); end
    step();
    n_chk++; if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd7, 32'd1}) begin n_fail++; $display("FAIL coll_second got=%0b/%0d/%0d want=1/7/1", we_o, waddr_o, wdata_o); end
    step();
    n_chk++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL coll_end_we got=%0b want=0", we_o); end
    n_chk++; if (rf[7] !== 32'd1) begin n_fail++; $display("FAIL coll_rf got=%0d want=1", rf[7]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      p0_valid = 1'b1; p0_addr = 5'(i + 1); p0_data = 32'h100 + 32'(i);
      #1;
      n_chk++; if (p0_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%0b want=1", i, p0_ready); end
      step();
      if (i >= 1) begin
        n_chk++;
        if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'(i), 32'h100 + 32'(i - 1)}) begin
          n_fail++; $display("FAIL b2b_write[%0d] got=%0b/%0d/%h want=1/%0d/%h", i, we_o, waddr_o, wdata_o, i, 32'h100 + 32'(i - 1));
        end
      end
    end
    idle_inputs();
    step();
    n_chk++; if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd8, 32'h107}) begin n_fail++; $display("FAIL b2b_last got=%0b/%0d/%h want=1/8/107", we_o, waddr_o, wdata_o); end
    step();
    n_chk++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end_we got=%0b want=0", we_o); end
    n_chk++; if (rf[1] !== 32'h100 || rf[8] !== 32'h107) begin n_fail++; $display("FAIL b2b_rf got=%h/%h want=100/107", rf[1], rf[8]); end
  endtask

  task automatic test_refill_order();
    p1_valid = 1'b1; p1_addr = 5'd10; p1_data = 32'hA;
    p0_valid = 1'b1; p0_addr = 5'd11; p0_data = 32'hB;
    step();
    p0_valid = 1'b0;
    p1_data = 32'hC;
    #1;
    n_chk++; if (p1_ready !== 1'b1) begin n_fail++; $display("FAIL refill_ready got=%0b want=1", p1_ready); end
    step();
    idle_inputs();
    #1;
    n_chk++; if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd10, 32'hA}) begin n_fail++; $display("FAIL refill_w1 got=%0b/%0d/%h want=1/10/a", we_o, waddr_o, wdata_o); end
    n_chk++; if (pending_o !== 32'h0000_0C00) begin n_fail++; $display("FAIL refill_pend got=%h want=00000c00", pending_o); end
    step();
    n_chk++; if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd11, 32'hB}) begin n_fail++; $display("FAIL refill_w2 got=%0b/%0d/%h want=1/11/b", we_o, waddr_o, wdata_o); end
    step();
    n_chk++; if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd10, 32'hC}) begin n_fail++; $display("FAIL refill_w3 got=%0b/%0d/%h want=1/10/c", we_o, waddr_o, wdata_o); end
    step();
    n_chk++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL refill_idle got=%0b want=1", idle_o); end
  endtask

  task automatic test_zero_reg();
    p1_valid = 1'b1; p1_addr = 5'd0; p1_data = 32'h55;
    #1;
    n_chk++; if (p1_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready got=%0b want=1", p1_ready); end
    step();
    idle_inputs();
    #1;
    n_chk++; if (pending_o !== '0) begin n_fail++; $display("FAIL zero_pend_t got=%h want=0", pending_o); end
    n_chk++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL zero_busy got=%0b want=0", idle_o); end
    step();
    n_chk++; if (we_o !== 1'b0 || pending_o !== '0) begin n_fail++; $display("FAIL zero_we got=%0b/%h want=0/0", we_o, pending_o); end
    n_chk++; if (waddr_o !== 5'd0 || wdata_o !== 32'h55) begin n_fail++; $display("FAIL zero_wport got=%0d/%h want=0/55", waddr_o, wdata_o); end
  endtask

  task automatic test_reset_midop();
    p0_valid = 1'b1; p0_addr = 5'd3; p0_data = 32'h33;
    p1_valid = 1'b1; p1_addr = 5'd4; p1_data = 32'h44;
    step();
    idle_inputs();
    #1;
    n_chk++; if (pending_o !== 32'h0000_0018) begin n_fail++; $display("FAIL midrst_pend_pre got=%h want=00000018", pending_o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_chk++; if (we_o !== 1'b0 || pending_o !== '0 || idle_o !== 1'b1) begin n_fail++; $display("FAIL midrst_clear got=%0b/%h/%0b want=0/0/1", we_o, pending_o, idle_o); end
    step();
    n_chk++; if (we_o !== 1'b0 || idle_o !== 1'b1) begin n_fail++; $display("FAIL midrst_after got=%0b/%0b want=0/1", we_o, idle_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_back_to_back();
    test_refill_order();
    test_zero_reg();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
